// File: rtl/present_tI_pkg.sv
// Shared definitions for the 3-share threshold PRESENT core: nibble width,
// G bit positions, buffer occupancy encoding and the per-share G function.
package present_tI_pkg;

   localparam int NIB_W = 4;

   localparam int G_X = 3;
   localparam int G_Y = 2;
   localparam int G_Z = 1;
   localparam int G_W = 0;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // One output share of G from the two other input shares (aj = share j, ak = share k).
   // Each quadratic term ab is split as a_j b_j ^ a_j b_k ^ a_k b_j.
   function automatic logic [NIB_W-1:0] g_share(input logic [NIB_W-1:0] aj,
                                                 input logic [NIB_W-1:0] ak);
      logic             q_yz;
      logic             q_yw;
      logic             q_xy;
      logic [NIB_W-1:0] res;
      q_yz = (aj[G_Y] & aj[G_Z]) ^ (aj[G_Y] & ak[G_Z]) ^ (ak[G_Y] & aj[G_Z]);
      q_yw = (aj[G_Y] & aj[G_W]) ^ (aj[G_Y] & ak[G_W]) ^ (ak[G_Y] & aj[G_W]);
      q_xy = (aj[G_X] & aj[G_Y]) ^ (aj[G_X] & ak[G_Y]) ^ (ak[G_X] & aj[G_Y]);
      res[G_X] = aj[G_X] ^ q_yz ^ q_yw;
      res[G_Y] = aj[G_W] ^ q_xy;
      res[G_Z] = aj[G_Y] ^ aj[G_Z];
      res[G_W] = aj[G_Z] ^ q_yw;
      return res;
   endfunction

endpackage

// File: rtl/sbox_quad_share.sv
// Combinational slice: one 4-bit output share of G from the two input shares
// it is allowed to see (never its own index).
import present_tI_pkg::*;

module sbox_quad_share (
   input  logic [NIB_W-1:0] aj,
   input  logic [NIB_W-1:0] ak,
   output logic [NIB_W-1:0] g
);

   assign g = g_share(aj, ak);

endmodule

// File: rtl/sbox_quad_stage.sv
// Registered 3-share G stage with a main + skid elastic buffer on valid/ready.
// Optional macro SBOX_REMASK_EN adds port r and refreshes the shares on capture.
import present_tI_pkg::*;

module sbox_quad_stage #(
   parameter int NIB = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NIB_W*NIB-1:0] x1,
   input  logic [NIB_W*NIB-1:0] x2,
   input  logic [NIB_W*NIB-1:0] x3,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NIB_W*NIB-1:0] y1,
   output logic [NIB_W*NIB-1:0] y2,
   output logic [NIB_W*NIB-1:0] y3,
   output logic [1:0]           occ
`ifdef SBOX_REMASK_EN
   ,
   input  logic [8*NIB-1:0]     r
`endif
);

   localparam int W = NIB_W * NIB;

   logic [2:0][W-1:0] x_sh;
   logic [2:0][W-1:0] g_sh;
   logic [2:0][W-1:0] cap_sh;

   logic [2:0][W-1:0] main_q, main_d;
   logic [2:0][W-1:0] skid_q, skid_d;
   occ_e              occ_q, occ_d;
   logic              in_ready_q, in_ready_d;

   logic in_fire;
   logic out_fire;

   assign x_sh[0] = x1;
   assign x_sh[1] = x2;
   assign x_sh[2] = x3;

   // Output share gi is fed by shares gi+1 and gi+2 only (non-completeness).
   genvar gi, gn;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_share_idx
         for (gn = 0; gn < NIB; gn++) begin : g_nib
            sbox_quad_share u_share (
               .aj (x_sh[(gi + 1) % 3][gn*NIB_W +: NIB_W]),
               .ak (x_sh[(gi + 2) % 3][gn*NIB_W +: NIB_W]),
               .g  (g_sh[gi][gn*NIB_W +: NIB_W])
            );
         end
      end

`ifdef SBOX_REMASK_EN
      for (gn = 0; gn < NIB; gn++) begin : g_remask
         assign cap_sh[0][gn*NIB_W +: NIB_W] = g_sh[0][gn*NIB_W +: NIB_W] ^ r[gn*8 +: 4];
         assign cap_sh[1][gn*NIB_W +: NIB_W] = g_sh[1][gn*NIB_W +: NIB_W] ^ r[gn*8+4 +: 4];
         assign cap_sh[2][gn*NIB_W +: NIB_W] = g_sh[2][gn*NIB_W +: NIB_W]
                                              ^ r[gn*8 +: 4] ^ r[gn*8+4 +: 4];
      end
`else
      for (gi = 0; gi < 3; gi++) begin : g_pass
         assign cap_sh[gi] = g_sh[gi];
      end
`endif
   endgenerate

   assign out_valid = (occ_q != OCC_EMPTY);
   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      occ_d  = occ_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (in_fire) begin
               main_d = cap_sh;
               occ_d  = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (in_fire && out_fire) begin
               main_d = cap_sh;
            end else if (in_fire) begin
               skid_d = cap_sh;
               occ_d  = OCC_TWO;
            end else if (out_fire) begin
               occ_d = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            // in_ready is low here, so only the drain can happen
            if (out_fire) begin
               main_d = skid_q;
               occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
      in_ready_d = (occ_d != OCC_TWO);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         occ_q      <= OCC_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         occ_q      <= occ_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign y1       = main_q[0];
   assign y2       = main_q[1];
   assign y3       = main_q[2];
   assign occ      = occ_q;
   assign in_ready = in_ready_q;

endmodule

// File: tb/tb_sbox_quad_stage.sv
// Directed bench for sbox_quad_stage (NIB=1): G table sweep, random share
// splits, back-pressure, mid-operation reset and the fixed-share capture.
module tb_sbox_quad_stage;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] x1, x2, x3;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] y1, y2, y3;
   logic [1:0] occ;
`ifdef SBOX_REMASK_EN
   logic [7:0] r;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // G(v) for v = 0..15, worked out by hand from the bit equations.
   logic [3:0] g_tab [16] = '{4'h0, 4'h4, 4'h3, 4'h7, 4'h2, 4'hF, 4'h9, 4'h4,
                              4'h8, 4'hC, 4'hB, 4'hF, 4'hE, 4'h3, 4'h5, 4'h8};

   sbox_quad_stage #(.NIB(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x1        (x1),
      .x2        (x2),
      .x3        (x3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y1        (y1),
      .y2        (y2),
      .y3        (y3),
      .occ       (occ)
`ifdef SBOX_REMASK_EN
      ,
      .r         (r)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] a, b, prev_y1, flip;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x1 = 4'h0; x2 = 4'h0; x3 = 4'h0;
`ifdef SBOX_REMASK_EN
      r = 8'h00;
`endif
      step();
      step();
      rst_n = 1'b1;
      check("reset_occ", occ, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_y1", y1, 0);
      check("reset_y2", y2, 0);
      check("reset_y3", y3, 0);

      // Unshared sweep streamed back to back: each result one cycle after acceptance.
      for (int v = 0; v < 16; v++) begin
         in_valid = 1'b1;
         x1 = 4'(v);
         x2 = 4'h0;
         x3 = 4'h0;
         step();
         $display("sweep x=0x%0h -> y=0x%0h", v, y1 ^ y2 ^ y3);
         check("sweep_xor", y1 ^ y2 ^ y3, g_tab[v]);
         check("sweep_out_valid", out_valid, 1);
         check("sweep_occ", occ, 1);
      end
      in_valid = 1'b0;
      step();
      check("sweep_drain_occ", occ, 0);
      check("sweep_drain_valid", out_valid, 0);

      // Random splits of 0x6, plus an x1-only flip that must leave y1 alone.
      in_valid = 1'b1;
      for (int n = 0; n < 1000; n++) begin
         a  = 4'($urandom);
         b  = 4'($urandom);
         x1 = a;
         x2 = b;
         x3 = 4'h6 ^ a ^ b;
         step();
         check("split_xor", y1 ^ y2 ^ y3, 4'h9);
         prev_y1 = y1;
         flip = 4'($urandom_range(1, 15));
         x1 = a ^ flip;
         step();
         check("flip_x1_y1", y1, prev_y1);
      end
      in_valid = 1'b0;
      step();
      check("split_drain_occ", occ, 0);

      // Back-pressure: fill main and skid, then hold with in_valid still asserted.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x2 = 4'h0; x3 = 4'h0;
      x1 = 4'h1;
      step();
      $display("bp accept x=0x1 occ=%0d", occ);
      check("bp_occ1", occ, 1);
      check("bp_ready1", in_ready, 1);
      x1 = 4'h2;
      step();
      $display("bp accept x=0x2 occ=%0d", occ);
      check("bp_occ2", occ, 2);
      check("bp_ready2", in_ready, 0);
      x1 = 4'h3;
      step();
      step();
      check("bp_hold_occ", occ, 2);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_head", y1 ^ y2 ^ y3, 4'h4);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      $display("bp release first -> y=0x%0h", y1 ^ y2 ^ y3);
      check("bp_second_data", y1 ^ y2 ^ y3, 4'h3);
      check("bp_after_first_occ", occ, 1);
      check("bp_after_first_ready", in_ready, 1);
      step();
      check("bp_empty_occ", occ, 0);
      check("bp_empty_valid", out_valid, 0);

      // Reset while full: everything buffered is thrown away.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x1 = 4'h5;
      step();
      x1 = 4'h9;
      step();
      check("rst_pre_occ", occ, 2);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst_mid_occ", occ, 0);
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_ready", in_ready, 1);
      check("rst_mid_y1", y1, 0);
      check("rst_mid_y2", y2, 0);
      check("rst_mid_y3", y3, 0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x1 = 4'hF;
      step();
      $display("post-reset x=0xf -> y=0x%0h", y1 ^ y2 ^ y3);
      check("rst_flow_xor", y1 ^ y2 ^ y3, 4'h8);
      check("rst_flow_occ", occ, 1);

      // Fixed shares x1=6, x2=x3=0: y1=y2=0, y3=G(6)=9 unless remasked by r=0xA5.
      x1 = 4'h6; x2 = 4'h0; x3 = 4'h0;
`ifdef SBOX_REMASK_EN
      r = 8'hA5;
`endif
      step();
      $display("fixed shares -> y1=0x%0h y2=0x%0h y3=0x%0h", y1, y2, y3);
`ifdef SBOX_REMASK_EN
      check("fixed_y1", y1, 4'h5);
      check("fixed_y2", y2, 4'hA);
      check("fixed_y3", y3, 4'h6);
`else
      check("fixed_y1", y1, 4'h0);
      check("fixed_y2", y2, 4'h0);
      check("fixed_y3", y3, 4'h9);
`endif
      check("fixed_xor", y1 ^ y2 ^ y3, 4'h9);
      in_valid = 1'b0;
      step();
      check("final_occ", occ, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
